pipe_mux_reg: RTL and testbench

- Parametrised N-channel, W-bit selector followed by a registered 2-entry skid buffer with valid/ready handshake.
- Generational successor to the fixed 4:1 32-bit combinational selector.
- Used at pipeline-stage boundaries (forwarding/operand select feeding the next stage), so stall backpressure never creates a combinational ready path.
- Full throughput: one transfer per cycle, 1-cycle latency.

---
 rtl/pipe_mux_reg_pkg.sv | 12 +
 rtl/mux_n_w.sv | 29 ++
 rtl/pipe_mux_reg.sv | 147 ++++++++++++++
 tb/tb_pipe_mux_reg.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mux_reg_pkg.sv
// Shared definitions for the pipe_mux_reg block: occupancy-encoded state values.
// The state value equals the number of buffered entries, so occupancy is the state itself.
// Encoding 3 is unreachable; the FSM treats it as empty.
package pipe_mux_reg_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

endpackage

// File: rtl/mux_n_w.sv
// Generic N:1 selector, WIDTH bits per channel, all-zero output for out-of-range select.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports:
//   data : N_CH*WIDTH flattened channels, channel i at [i*WIDTH +: WIDTH]
//   sel  : binary channel index
//   y    : selected channel, or zero when sel >= N_CH
module mux_n_w #(
   parameter  int WIDTH = 32,
   parameter  int N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH*WIDTH-1:0] data,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      y
);

   // Zero default covers every unmatched sel value, so no latch and no X
   // when N_CH is not a power of two.
   always_comb begin
      y = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel == SEL_W'(i)) begin
            y = data[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/pipe_mux_reg.sv
// N-channel selector feeding a registered 2-entry skid buffer (valid/ready).
// Latency: 1 cycle from input transfer to out_valid; full throughput.
// Backpressure: in_ready comes from state only, never combinationally from out_ready.
// Ports:
//   clk, rst (async active-high), flush (sync discard of all entries)
//   ch_data/sel/in_valid/in_ready : upstream side, sel sampled with the transfer
//   out_data/out_valid/out_ready  : downstream side, out_data is the head entry
//   occupancy                     : entries held (0..2)
//   sel_err (only with PIPE_MUX_SEL_ERR_EN) : sticky flag, set by a push with sel >= N_CH
module pipe_mux_reg
   import pipe_mux_reg_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [N_CH*WIDTH-1:0] ch_data,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            occupancy
`ifdef PIPE_MUX_SEL_ERR_EN
   ,
   output logic                  sel_err
`endif
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic [WIDTH-1:0] mux_y;
   logic             push;
   logic             pop;

   mux_n_w #(
      .WIDTH (WIDTH),
      .N_CH  (N_CH)
   ) u_mux (
      .data (ch_data),
      .sel  (sel),
      .y    (mux_y)
   );

   // Ready depends on the state register and reset only.
   assign in_ready = (state_q != ST_TWO) & ~rst;
   assign push     = in_valid & in_ready;
   assign pop      = out_valid & out_ready;
   assign out_data = main_q;

   // The unreachable encoding reads as empty.
   always_comb begin
      out_valid = 1'b0;
      occupancy = 2'd0;
      case (state_q)
         ST_ONE: begin
            out_valid = 1'b1;
            occupancy = 2'd1;
         end
         ST_TWO: begin
            out_valid = 1'b1;
            occupancy = 2'd2;
         end
         default: begin
            out_valid = 1'b0;
            occupancy = 2'd0;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Buffered data is left stale; only the state is cleared.
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_ONE: begin
               if (push && pop) begin
                  main_d = mux_y;
               end else if (push) begin
                  state_d = ST_TWO;
                  skid_d  = mux_y;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               if (push) begin
                  state_d = ST_ONE;
                  main_d  = mux_y;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef PIPE_MUX_SEL_ERR_EN
   logic sel_err_q, sel_err_d;

   always_comb begin
      sel_err_d = sel_err_q;
      if (push && (int'(sel) >= N_CH)) begin
         sel_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= sel_err_d;
      end
   end

   assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Bench for pipe_mux_reg: directed vectors on a 4-channel and a 3-channel instance,
// then a random valid/ready run against a queue scoreboard.
module tb_pipe_mux_reg;

   localparam logic [31:0] DA = 32'hAAAA_AAAA;
   localparam logic [31:0] DB = 32'hBBBB_BBBB;
   localparam logic [31:0] DC = 32'hCCCC_CCCC;
   localparam logic [31:0] DD = 32'hDDDD_DDDD;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         flush = 1'b0;
   logic [127:0] ch_data;
   logic [1:0]   sel = 2'd0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [1:0]   occupancy;

   logic [95:0]  ch3_data;
   logic [1:0]   sel3 = 2'd0;
   logic         in_valid3 = 1'b0;
   logic         in_ready3;
   logic [31:0]  out_data3;
   logic         out_valid3;
   logic         out_ready3 = 1'b0;
   logic [1:0]   occupancy3;
`ifdef PIPE_MUX_SEL_ERR_EN
   logic         sel_err;
   logic         sel_err3;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_mux_reg #(.WIDTH(32), .N_CH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .ch_data   (ch_data),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .occupancy (occupancy)
`ifdef PIPE_MUX_SEL_ERR_EN
      ,
      .sel_err   (sel_err)
`endif
   );

   pipe_mux_reg #(.WIDTH(32), .N_CH(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .ch_data   (ch3_data),
      .sel       (sel3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .out_data  (out_data3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .occupancy (occupancy3)
`ifdef PIPE_MUX_SEL_ERR_EN
      ,
      .sel_err   (sel_err3)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs are changed on the falling edge; step crosses one rising edge
   // and returns at the next falling edge where outputs are sampled.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [31:0] sb_q[$];
   logic [31:0] exp_d;
   logic        push_m, pop_m, rdy_before;

   initial begin
      ch_data  = {DD, DC, DB, DA};
      ch3_data = {DC, DB, DA};

      // Reset
      #1 rst = 1'b1;
      @(negedge clk);
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1'b0;
      #1 chk("rel_in_ready", in_ready, 1);
      @(negedge clk);

      // Streaming at one transfer per cycle
      out_ready = 1'b1; in_valid = 1'b1; sel = 2'd2;
      step();
      chk("s1_data", out_data, DC);
      chk("s1_valid", out_valid, 1);
      chk("s1_occ", occupancy, 1);
      sel = 2'd3;
      step();
      chk("s2_data", out_data, DD);
      chk("s2_occ", occupancy, 1);
      sel = 2'd0;
      step();
      chk("s3_data", out_data, DA);
      in_valid = 1'b0;
      step();
      chk("s4_valid", out_valid, 0);
      chk("s4_occ", occupancy, 0);

      // Fill to two entries under stall, then drain
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
      step();
      chk("f1_occ", occupancy, 1);
      chk("f1_data", out_data, DA);
      sel = 2'd1;
      step();
      chk("f2_occ", occupancy, 2);
      chk("f2_in_ready", in_ready, 0);
      chk("f2_data", out_data, DA);
      in_valid = 1'b0;
      step();
      chk("f3_hold_data", out_data, DA);
      chk("f3_occ", occupancy, 2);
      out_ready = 1'b1;
      step();
      chk("f4_data", out_data, DB);
      chk("f4_occ", occupancy, 1);
      step();
      chk("f5_valid", out_valid, 0);
      chk("f5_in_ready", in_ready, 1);

      // Flush with a push in the same cycle
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd2;
      step();
      sel = 2'd3;
      step();
      chk("fl0_occ", occupancy, 2);
      flush = 1'b1; sel = 2'd1;
      step();
      chk("fl1_occ", occupancy, 0);
      chk("fl1_valid", out_valid, 0);
      chk("fl1_in_ready", in_ready, 1);
      flush = 1'b0; in_valid = 1'b0;
      step();
      chk("fl2_occ", occupancy, 0);
      in_valid = 1'b1; sel = 2'd0;
      step();
      chk("fl3_data", out_data, DA);
      chk("fl3_occ", occupancy, 1);

      // Asynchronous reset in the middle of a cycle, buffer full
      sel = 2'd1;
      step();
      chk("ar0_occ", occupancy, 2);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_occ", occupancy, 0);
      chk("ar_data", out_data, 0);
      chk("ar_in_ready", in_ready, 0);
      @(negedge clk);
      step();
      chk("ar_hold_in_ready", in_ready, 0);
      rst = 1'b0;
      #1 chk("ar_rel_in_ready", in_ready, 1);
      chk("ar_rel_occ", occupancy, 0);
      @(negedge clk);

      // Three-channel instance: out-of-range select gives zero
`ifdef PIPE_MUX_SEL_ERR_EN
      chk("n3_err0", sel_err3, 0);
`endif
      out_ready3 = 1'b1; in_valid3 = 1'b1; sel3 = 2'd3;
      step();
      chk("n3_zero_data", out_data3, 0);
      chk("n3_zero_valid", out_valid3, 1);
`ifdef PIPE_MUX_SEL_ERR_EN
      chk("n3_err1", sel_err3, 1);
`endif
      sel3 = 2'd2;
      step();
      chk("n3_c_data", out_data3, DC);
      in_valid3 = 1'b0;
      step();
`ifdef PIPE_MUX_SEL_ERR_EN
      chk("n3_err_sticky", sel_err3, 1);
      chk("n4_err_clean", sel_err, 0);
      rst = 1'b1;
      #1 chk("n3_err_rst", sel_err3, 0);
      rst = 1'b0;
      @(negedge clk);
`endif

      // Random valid/ready against a scoreboard
      for (int cyc = 0; cyc < 10000; cyc++) begin
         ch_data   = {$urandom, $urandom, $urandom, $urandom};
         sel       = 2'($urandom_range(0, 3));
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 55);
         #1;
         chk("rnd_valid", out_valid, (sb_q.size() != 0));
         chk("rnd_in_ready", in_ready, (sb_q.size() < 2));
         rdy_before = in_ready;
         out_ready = ~out_ready;
         #1 chk("rnd_ready_indep", in_ready, rdy_before);
         out_ready = ~out_ready;
         #1;
         push_m = in_valid & (sb_q.size() < 2);
         pop_m  = out_ready & (sb_q.size() != 0);
         if (pop_m) begin
            exp_d = sb_q.pop_front();
            chk("rnd_data", out_data, exp_d);
         end
         if (push_m) begin
            sb_q.push_back(ch_data[sel*32 +: 32]);
         end
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (sb_q.size() != 0) begin
            exp_d = sb_q.pop_front();
            chk("drain_data", out_data, exp_d);
         end
         step();
      end
      chk("drain_empty", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
